serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Time-multiplexes one shared half-adder cell to perform W-bit addition bit-serially.
//  Each operand bit takes two passes through the cell: A^B, then partial sum ^ carry.
//  Sits between a requester (start/done handshake) and the shared half-adder datapath.
// PARAMETERS
//  W      8                 operand width in bits, W >= 1
//  CNT_W  $clog2(W)>0?..:1  bit-index counter width (localparam, derived from W)
// PORTS
//  clk    in   1  rising-edge clock (single clock domain)
//  rst    in   1  synchronous, active-high reset
//  start  in   1  request; sampled only in IDLE
//  a      in   W  operand A; captured on accepted start
//  b      in   W  operand B; captured on accepted start
//  busy   out  1  high in HA1/HA2
//  done   out  1  one-cycle pulse; sum/cout valid
//  sum    out  W  result; held until next accepted start
//  cout   out  1  carry out of bit W-1; held with sum
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0, carry=0, idx=0.
//  - States: IDLE -> HA1 -> HA2 -> (HA1 | DONE) -> IDLE.
//  - IDLE: start=1 -> latch a,b into shift regs; carry=0 (or cin, see CONFIG); idx=0; go HA1.
//  - HA1: cell(a_sh[0], b_sh[0]) -> reg p=sum, g1=carry; go HA2.
//  - HA2: cell(p, carry) -> bit s, g2; sum_sh <= {s, sum_sh[W-1:1]}; carry <= g1|g2;
//    shift a_sh,b_sh right; idx==W-1 ? go DONE : idx++, go HA1.
//  - DONE: drive sum=sum_sh, cout=carry, done=1 for exactly one cycle; go IDLE.
//  - Latency: start sampled at edge 0 -> done high in the cycle after edge 2W (W=8: 16).
//  - start in HA1/HA2/DONE ignored, not queued; a/b changes after capture have no effect.
//  - Back-to-back: start may be asserted in the cycle after done; accepted from IDLE.
//  - rst mid-operation: aborts immediately, all outputs to reset values, no done pulse.
//  - g1 and g2 never both 1; carry width 1; result modulo 2^W, overflow only via cout.
//  - W=1: single HA1/HA2 pair, done after edge 2.
// CONFIGURATION
//  - Macro SERIAL_ADD_CIN_EN defined: extra port `cin in 1`, captured on accepted start as
//    initial carry; result = a + b + cin.
//  - Macro undefined: no cin port; initial carry fixed 0; result = a + b.
// STRUCTURE
//  - Package serial_add_pkg: state enum {IDLE, HA1, HA2, DONE} (2-bit encoding),
//    default width constant SA_W_DEFAULT=8.
//  - One sub-module: ha_cell (1-bit half adder: s=x^y, c=x&y), instantiated exactly once;
//    its inputs muxed by state (HA1: a_sh[0],b_sh[0]; HA2: p,carry).
//  - Everything else (FSM, shift regs, idx counter) in serial_add_ctrl.
// TESTING
//  - W=8, reset then a=0x00,b=0x00,start -> done after 16 edges, sum=0x00, cout=0.
//  - a=0xFF,b=0x01 -> sum=0x00, cout=1; a=0xA5,b=0x5A -> sum=0xFF, cout=0.
//  - start held high through a run with a=0x10,b=0x20 changing mid-run -> one done only,
//    sum=0x30; busy=1 for 16 cycles.
//  - rst at cycle 7 of a run -> next cycle busy=0,sum=0,cout=0; no done; new start OK.
//  - Back-to-back: 0x7F+0x01 then start in cycle after done with 0x80+0x80 ->
//    sums 0x80/cout0 then 0x00/cout1.
//  - SERIAL_ADD_CIN_EN: a=0xFF,b=0x00,cin=1 -> sum=0x00,cout=1; randomized vs a+b+cin.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned SA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HA1  = 2'd1,
      HA2  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake bundle for serial_add_ctrl.
// Optional carry-in signal present when SERIAL_ADD_CIN_EN is defined.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int unsigned W = SA_W_DEFAULT
) ();

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
`ifdef SERIAL_ADD_CIN_EN
   logic         cin;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

`ifdef SERIAL_ADD_CIN_EN
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`else
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/ha_cell.sv
// One-bit half adder; the only arithmetic cell of the serial adder.
module ha_cell (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder sequencing a single shared half-adder cell twice per bit.
// Define SERIAL_ADD_CIN_EN to add a carry-in captured with the operands.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned W = SA_W_DEFAULT
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = ($clog2(W) > 0) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(W - 1);

   state_t           state, state_n;
   logic [W-1:0]     a_sh, a_sh_n;
   logic [W-1:0]     b_sh, b_sh_n;
   logic [W-1:0]     sum_sh, sum_sh_n;
   logic [CNT_W-1:0] idx, idx_n;
   logic             carry, carry_n;
   logic             p, p_n;
   logic             g1, g1_n;
   logic             busy, busy_n;
   logic             done, done_n;
   logic [W-1:0]     sum, sum_n;
   logic             cout, cout_n;
   logic             carry_init;
   logic             ha_x, ha_y, ha_s, ha_c;

`ifdef SERIAL_ADD_CIN_EN
   assign carry_init = bus.cin;
`else
   assign carry_init = 1'b0;
`endif

   // HA1 adds the operand bits; HA2 folds the running carry into the partial sum.
   assign ha_x = (state == HA2) ? p     : a_sh[0];
   assign ha_y = (state == HA2) ? carry : b_sh[0];

   ha_cell u_ha (
      .x (ha_x),
      .y (ha_y),
      .s (ha_s),
      .c (ha_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         p      <= 1'b0;
         g1     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state  <= state_n;
         a_sh   <= a_sh_n;
         b_sh   <= b_sh_n;
         sum_sh <= sum_sh_n;
         idx    <= idx_n;
         carry  <= carry_n;
         p      <= p_n;
         g1     <= g1_n;
         busy   <= busy_n;
         done   <= done_n;
         sum    <= sum_n;
         cout   <= cout_n;
      end
   end

   always_comb begin
      state_n  = state;
      a_sh_n   = a_sh;
      b_sh_n   = b_sh;
      sum_sh_n = sum_sh;
      idx_n    = idx;
      carry_n  = carry;
      p_n      = p;
      g1_n     = g1;
      busy_n   = busy;
      done_n   = 1'b0;
      sum_n    = sum;
      cout_n   = cout;

      case (state)
         IDLE: begin
            if (bus.start) begin
               a_sh_n  = bus.a;
               b_sh_n  = bus.b;
               carry_n = carry_init;
               idx_n   = '0;
               busy_n  = 1'b1;
               state_n = HA1;
            end
         end
         HA1: begin
            p_n     = ha_s;
            g1_n    = ha_c;
            state_n = HA2;
         end
         HA2: begin
            // g1 and g2 are mutually exclusive, so OR is the full carry.
            sum_sh_n = W'({ha_s, sum_sh} >> 1);
            carry_n  = g1 | ha_c;
            a_sh_n   = a_sh >> 1;
            b_sh_n   = b_sh >> 1;
            if (idx == IDX_LAST) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               sum_n   = sum_sh_n;
               cout_n  = carry_n;
               state_n = DONE;
            end else begin
               idx_n   = CNT_W'(idx + 1'b1);
               state_n = HA1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = sum;
   assign bus.cout = cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at W=8; optional carry-in vectors under SERIAL_ADD_CIN_EN.
module tb_serial_add_ctrl;

   localparam int unsigned W     = 8;
   localparam int unsigned LAT   = 2 * W;
   localparam int unsigned BOUND = 100;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   serial_add_ctrl_if #(.W(W)) bus ();

   serial_add_ctrl #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Issues one request at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input bit hold_start, output logic [W-1:0] got_sum,
                         output logic got_cout, output int lat, output int busy_cnt);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
`ifdef SERIAL_ADD_CIN_EN
      bus.cin   = cin;
`else
      if (cin) $display("note: cin ignored in this build");
`endif
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < BOUND) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (lat == 5) begin
            bus.a = ~a;
            bus.b = ~b;
`ifdef SERIAL_ADD_CIN_EN
            bus.cin = ~cin;
`endif
         end
         @(negedge clk);
         lat++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = 1'b0;
      got_sum   = bus.sum;
      got_cout  = bus.cout;
   endtask

   vec_t         vecs[8];
   logic [W-1:0] s;
   logic         c;
   int           lat;
   int           bcnt;
   int           done_seen;

   initial begin
      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
      vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
      vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
`ifdef SERIAL_ADD_CIN_EN
      bus.cin   = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_sum",  32'(bus.sum),  32'd0);
      chk("reset_cout", 32'(bus.cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven vectors, with an idle cycle between requests.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, c, lat, bcnt);
         chk($sformatf("vec%0d_sum", i),  32'(s),    32'(vecs[i].exp_sum));
         chk($sformatf("vec%0d_cout", i), 32'(c),    32'(vecs[i].exp_cout));
         chk($sformatf("vec%0d_lat", i),  32'(lat),  32'(LAT));
         chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(LAT));
         @(negedge clk);
         chk($sformatf("vec%0d_pulse", i), 32'(bus.done), 32'd0);
         @(negedge clk);
      end

      // start held through the run with operands changing: one done, original operands used.
      run_op(8'h10, 8'h20, 1'b0, 1'b1, s, c, lat, bcnt);
      chk("hold_sum",  32'(s),    32'h30);
      chk("hold_cout", 32'(c),    32'd0);
      chk("hold_lat",  32'(lat),  32'(LAT));
      chk("hold_busy", 32'(bcnt), 32'(LAT));
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      chk("hold_single_done", 32'(done_seen), 32'd0);

      // Back-to-back: second start asserted in the idle cycle right after done.
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, s, c, lat, bcnt);
      chk("b2b1_sum",  32'(s),   32'h80);
      chk("b2b1_cout", 32'(c),   32'd0);
      @(negedge clk);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, s, c, lat, bcnt);
      chk("b2b2_sum",  32'(s),   32'h00);
      chk("b2b2_cout", 32'(c),   32'd1);
      chk("b2b2_lat",  32'(lat), 32'(LAT));
      @(negedge clk);

      // Leave a nonzero result, then abort a run with reset partway through.
      run_op(8'hF0, 8'h0F, 1'b0, 1'b0, s, c, lat, bcnt);
      chk("pre_rst_sum", 32'(s), 32'hFF);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h55;
      bus.b     = 8'hAA;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sum",  32'(bus.sum),  32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      done_seen = 0;
      repeat (24) begin
         if (bus.done === 1'b1) done_seen++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      run_op(8'h12, 8'h34, 1'b0, 1'b0, s, c, lat, bcnt);
      chk("post_rst_sum", 32'(s),   32'h46);
      chk("post_rst_lat", 32'(lat), 32'(LAT));
      @(negedge clk);

`ifdef SERIAL_ADD_CIN_EN
      run_op(8'hFF, 8'h00, 1'b1, 1'b0, s, c, lat, bcnt);
      chk("cin_sum",  32'(s), 32'h00);
      chk("cin_cout", 32'(c), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         logic [W:0]   ref_v;
         ra    = W'($urandom_range(255));
         rb    = W'($urandom_range(255));
         rc    = 1'($urandom_range(1));
         ref_v = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
         run_op(ra, rb, rc, 1'b0, s, c, lat, bcnt);
         chk($sformatf("rnd%0d_sum", i),  32'(s), 32'(ref_v[W-1:0]));
         chk($sformatf("rnd%0d_cout", i), 32'(c), 32'(ref_v[W]));
         @(negedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
